// File: rtl/gbuff_stream_reader.sv
// gbuff_stream_reader: walks a wrapping address range of the global buffer,
// captures the one-cycle-latency read data into a small FIFO and presents it
// as a valid/ready stream with a last flag.
module gbuff_stream_reader #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] base_i,
  input  logic [ADDR_BITS:0]   len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 gb_wr_en_o,
  output logic [ADDR_BITS-1:0] gb_index_o,
  input  logic [DATA_BITS-1:0] gb_data_i,
  output logic                 m_valid_o,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]        DEPTH_W  = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] LEN_ZERO = {(ADDR_BITS+1){1'b0}};
  localparam logic [ADDR_BITS:0] LEN_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_r, state_nxt;
  logic                   busy_r, done_r;
  logic [ADDR_BITS:0]     len_r, cnt_r, cnt_inc_s;
  logic [ADDR_BITS-1:0]   index_r;
  // iss_r: gb_index_o holds an issued address this cycle.
  // cap_r: gb_data_i carries the word for last cycle's issue and is captured now.
  logic                   iss_r, iss_last_r, cap_r, cap_last_r;

  logic [FIFO_DEPTH-1:0][DATA_BITS-1:0] mem_data_r;
  logic [FIFO_DEPTH-1:0]                mem_last_r;
  logic [PW-1:0]                        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]                        count_r;

  logic                   beat_s, room_s, issue_s, start_s, head_last_s;
  logic [CW:0]            occ_s;

  // Handshake, slot reservation and issue decision.
  always_comb begin
    beat_s      = (count_r != {CW{1'b0}}) & m_ready_i;
    head_last_s = mem_last_r[rd_ptr_r];
    // Count every word that may still land in the FIFO, so a newly issued
    // index always has a slot when its data arrives two edges later.
    occ_s       = {1'b0, count_r} + {{CW{1'b0}}, cap_r} + {{CW{1'b0}}, iss_r};
    room_s      = occ_s < (DEPTH_W + {{CW{1'b0}}, beat_s});
    cnt_inc_s   = cnt_r + LEN_ONE;
    start_s     = (state_r == IDLE) & start_i & (len_i != LEN_ZERO);
    issue_s     = (state_r == RUN) & (cnt_r != len_r) & room_s;
  end

  // Next-state logic of the transfer FSM.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          if (len_i == LEN_ZERO) state_nxt = DONE;
          else                   state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == len_r) state_nxt = DRAIN;
        else                state_nxt = RUN;
      end
      DRAIN: begin
        if (beat_s & head_last_s) state_nxt = DONE;
        else                      state_nxt = DRAIN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      busy_r  <= (state_nxt != IDLE);
      done_r  <= (state_nxt == DONE);
    end
  end

  // Address issue and read-latency pipeline tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_r      <= LEN_ZERO;
      cnt_r      <= LEN_ZERO;
      index_r    <= {ADDR_BITS{1'b0}};
      iss_r      <= 1'b0;
      iss_last_r <= 1'b0;
      cap_r      <= 1'b0;
      cap_last_r <= 1'b0;
    end else begin
      cap_r      <= iss_r;
      cap_last_r <= iss_last_r;
      if (start_s) begin
        len_r      <= len_i;
        cnt_r      <= LEN_ONE;
        index_r    <= base_i;
        iss_r      <= 1'b1;
        iss_last_r <= (len_i == LEN_ONE);
      end else if (issue_s) begin
        cnt_r      <= cnt_inc_s;
        index_r    <= index_r + ADDR_BITS'(1'b1);
        iss_r      <= 1'b1;
        iss_last_r <= (cnt_inc_s == len_r);
      end else begin
        iss_r      <= 1'b0;
        iss_last_r <= 1'b0;
      end
    end
  end

  // Output FIFO: unconditional capture of in-flight reads, pop on each beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_data_r <= {(FIFO_DEPTH*DATA_BITS){1'b0}};
      mem_last_r <= {FIFO_DEPTH{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (cap_r) begin
        mem_data_r[wr_ptr_r] <= gb_data_i;
        mem_last_r[wr_ptr_r] <= cap_last_r;
        wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (beat_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      else        rd_ptr_r <= rd_ptr_r;
      count_r <= count_r + CW'(cap_r) - CW'(beat_s);
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign gb_wr_en_o = 1'b0;
  assign gb_index_o = index_r;
  assign m_valid_o  = (count_r != {CW{1'b0}});
  assign m_data_o   = mem_data_r[rd_ptr_r];
  assign m_last_o   = m_valid_o & head_last_s;

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Scoreboard bench for gbuff_stream_reader: a behavioural one-cycle-latency
// buffer model feeds the DUT; expected words are queued when a transfer is
// started and popped as beats are observed.
module tb_gbuff_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] base_i;
  logic [8:0] len_i;
  logic       busy_o, done_o, gb_wr_en_o;
  logic [7:0] gb_index_o;
  logic [7:0] gb_data;
  logic       m_valid_o, m_last_o, m_ready;
  logic [7:0] m_data_o;

  logic [7:0] gbuff [256];
  logic [8:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;
  int n_lasts = 0;

  gbuff_stream_reader #(.ADDR_BITS(8), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .gb_wr_en_o(gb_wr_en_o),
    .gb_index_o(gb_index_o), .gb_data_i(gb_data),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  // Buffer model: data_out follows the presented index one cycle later.
  always @(posedge clk) gb_data <= gbuff[gb_index_o];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_expected(input int base, input int len);
    for (int k = 0; k < len; k++)
      exp_q.push_back({1'(k == len - 1), gbuff[8'(base + k)]});
  endtask

  // Stream monitor: scoreboard pop per beat and stall-stability check.
  task automatic monitor();
    logic       stall_prev;
    logic [8:0] prev;
    stall_prev = 1'b0;
    prev = 9'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_eq("stall_valid", 32'(m_valid_o), 32'(1));
          check_eq("stall_data", 32'({m_last_o, m_data_o}), 32'(prev));
        end
        if (m_valid_o && m_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_beat", 32'(exp_q.size()), 32'(1));
          end else begin
            check_eq("data", 32'(m_data_o), 32'(exp_q[0][7:0]));
            check_eq("last", 32'(m_last_o), 32'(exp_q[0][8]));
            void'(exp_q.pop_front());
          end
          n_beats++;
          if (m_last_o) n_lasts++;
        end
        stall_prev = m_valid_o && !m_ready;
        prev = {m_last_o, m_data_o};
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"},  32'(busy_o), 32'(0));
    check_eq({tag, "_done"},  32'(done_o), 32'(0));
    check_eq({tag, "_wren"},  32'(gb_wr_en_o), 32'(0));
    check_eq({tag, "_index"}, 32'(gb_index_o), 32'(0));
    check_eq({tag, "_valid"}, 32'(m_valid_o), 32'(0));
    check_eq({tag, "_data"},  32'(m_data_o), 32'(0));
    check_eq({tag, "_last"},  32'(m_last_o), 32'(0));
  endtask

  // Cycle-exact transfer with m_ready held high; caller is just past a posedge.
  task automatic timed_xfer(input int base, input int len);
    push_expected(base, len);
    start_i = 1'b1; base_i = 8'(base); len_i = 9'(len);
    for (int c = 1; c <= len + 4; c++) begin
      @(posedge clk); #1; start_i = 1'b0;
      @(negedge clk);
      check_eq("t_busy",  32'(busy_o),    32'(c <= len + 3));
      check_eq("t_done",  32'(done_o),    32'(c == len + 3));
      check_eq("t_valid", 32'(m_valid_o), 32'(c >= 3 && c <= len + 2));
      check_eq("t_last",  32'(m_last_o),  32'(c == len + 2));
      if (c <= len) check_eq("t_index", 32'(gb_index_o), 32'((base + c - 1) % 256));
    end
    @(posedge clk); #1;
  endtask

  // Transfer run until done_o within a budget, optional random backpressure
  // and an optional ignored second start mid-transfer.
  task automatic run_xfer(input string tag, input int base, input int len,
                          input bit rnd, input bit inject);
    int b0, l0, n;
    b0 = n_beats; l0 = n_lasts; n = 0;
    push_expected(base, len);
    start_i = 1'b1; base_i = 8'(base); len_i = 9'(len);
    do begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (inject && n == 3) begin
        start_i = 1'b1; base_i = 8'd200; len_i = 9'd3;
      end
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end while (!done_o && n < 2000);
    check_eq({tag, "_done_in_time"}, 32'(n < 2000), 32'(1));
    #2;
    check_eq({tag, "_beats"}, 32'(n_beats - b0), 32'(len));
    check_eq({tag, "_lasts"}, 32'(n_lasts - l0), 32'(len > 0));
    check_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'(0));
    m_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_idle_after"}, 32'(busy_o), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n;
    rst = 1'b1; start_i = 1'b0; base_i = 8'd0; len_i = 9'd0; m_ready = 1'b1;
    for (int i = 0; i < 256; i++) gbuff[i] = 8'(i + 16);
    fork
      monitor();
    join_none
    #12;
    check_reset_values("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic stream and wrap past the top address.
    timed_xfer(5, 4);
    timed_xfer(254, 4);

    // Zero length: done in cycle 1, no beat.
    b0 = n_beats;
    start_i = 1'b1; base_i = 8'd9; len_i = 9'd0;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1; start_i = 1'b0;
      @(negedge clk);
      check_eq("z_busy",  32'(busy_o),    32'(c == 1));
      check_eq("z_done",  32'(done_o),    32'(c == 1));
      check_eq("z_valid", 32'(m_valid_o), 32'(0));
    end
    @(posedge clk); #1;
    check_eq("z_beats", 32'(n_beats - b0), 32'(0));

    // Backpressure, full length, start while busy.
    run_xfer("bp", 100, 16, 1'b1, 1'b0);
    run_xfer("bp2", 250, 12, 1'b1, 1'b0);
    run_xfer("full", 0, 256, 1'b0, 1'b0);
    run_xfer("busy_start", 10, 6, 1'b0, 1'b1);

    // Asynchronous reset at word 3 of 8.
    b0 = n_beats; n = 0;
    push_expected(50, 8);
    start_i = 1'b1; base_i = 8'd50; len_i = 9'd8;
    do begin
      @(posedge clk); #1; start_i = 1'b0;
      @(negedge clk); #2;
      n++;
    end while (n_beats - b0 < 3 && n < 50);
    check_eq("ar_reached_word3", 32'(n_beats - b0), 32'(3));
    rst = 1'b1;
    #1;
    check_reset_values("ar");
    repeat (2) @(negedge clk);
    #2; rst = 1'b0;
    @(posedge clk); #1;
    run_xfer("after_rst", 7, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gbuff_stream_reader.md
# gbuff_stream_reader

Read-side engine for the global buffer. On a start command it walks a contiguous, wrapping address range, drives the buffer's index/wr_en port, and captures the buffer's one-cycle-latency read data into a small output FIFO. It presents the words as a valid/ready stream with a last flag, so downstream compute (PE array feeders) can apply backpressure without losing words. One reader owns the buffer port while busy; write arbitration is outside this block.

## Interface

- ADDR_BITS, 8, global buffer address width; depth = 2**ADDR_BITS
- DATA_BITS, 8, word width
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥ 2)

- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  start pulse, sampled only when busy_o=0
- base_i  input  ADDR_BITS  first address, captured with start_i
- len_i  input  ADDR_BITS+1  word count 0..2**ADDR_BITS, captured with start_i
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse at end of transfer
- gb_wr_en_o  output  1  buffer write enable, constant 0
- gb_index_o  output  ADDR_BITS  buffer address, registered
- gb_data_i  input  DATA_BITS  buffer data_out, valid the cycle after the index was presented
- m_valid_o  output  1  stream word valid
- m_data_o  output  DATA_BITS  stream word (FIFO head)
- m_last_o  output  1  final word of the transfer, qualified by m_valid_o
- m_ready_i  input  1  downstream accept; a beat is m_valid_o & m_ready_i

## Operation

- States: IDLE, RUN (indices still to issue), DRAIN (all issued, FIFO/in-flight not empty), DONE (one cycle, done_o=1) → IDLE.
- IDLE + start_i, len_i>0: capture base/len, go RUN. If len_i=0, go DONE directly; no index is issued and no beat occurs.
- start_i is ignored while busy_o=1 (RUN, DRAIN, DONE).
- Issue k (k=0..len-1) presents gb_index_o = (base + k) mod 2**ADDR_BITS. Wrap past the top address is silent.
- The index counts as issued in the cycle it is on gb_index_o. gb_data_i is written into the FIFO unconditionally in the next cycle.
- Issue rule: an index is presented only if (FIFO count + in-flight reads − beats this cycle) leaves a free slot at capture time. The FIFO never overflows.
- When not issuing, gb_index_o holds its last value. The buffer's resulting reads are discarded: no capture occurs.
- m_last_o = 1 when the head entry is word len-1 (tag bit stored per entry).
- RUN → DRAIN after the last index is issued. DRAIN → DONE on the cycle after the m_last_o beat. DONE → IDLE.
- busy_o = 1 in RUN, DRAIN, DONE.
- m_data_o / m_valid_o are stable while m_valid_o=1 & m_ready_i=0.
- Reset (any time, including mid-transfer): state IDLE, FIFO emptied, in-flight discarded, all counters 0.
- Reset values: busy_o=0, done_o=0, gb_wr_en_o=0, gb_index_o=0, m_valid_o=0, m_data_o=0, m_last_o=0.

## Timing

- Cycle 0: start_i=1 in IDLE.
- Cycle 1: busy_o=1, gb_index_o=base.
- Cycle 2: buffer data valid on gb_data_i, captured at end of cycle.
- Cycle 3: m_valid_o=1, m_data_o=gbuff[base].
- With m_ready_i held 1: one beat per cycle, no bubbles after the first word. Last beat in cycle len+2, done_o=1 in cycle len+3, busy_o=0 in cycle len+4; a new start is accepted in that cycle.
- len=0: done_o=1 in cycle 1, busy_o=1 only in cycle 1.
- With backpressure: issue stalls within one cycle of the FIFO filling. On resume, throughput returns to 1 beat/cycle.

## Test plan

- Basic stream: buffer preloaded gbuff[i]=i+16, base=5, len=4, m_ready_i=1 → data 21,22,23,24 in cycles 3–6, m_last_o only in cycle 6, done_o cycle 7.
- Wrap: ADDR_BITS=8, base=254, len=4 → indices 254,255,0,1 issued; stream matches gbuff at those addresses in order.
- Backpressure: len=16, m_ready_i random ~50% → all 16 words in order, none duplicated or dropped. No capture occurs while the FIFO is full. m_data_o is stable during stalls.
- Zero length / full length: len=0 → done_o in cycle 1, no m_valid_o. len=256 → exactly 256 beats, last one flagged.
- Start while busy: second start_i mid-transfer with other base/len → ignored; the first transfer completes unchanged.
- Async reset mid-transfer: assert rst_i between clock edges at word 3 of 8 → outputs are at reset values immediately. After release, a new start with len=2 produces exactly 2 beats, with no stale words.
